// File: rtl/sync_filter_event_if.sv
// Event-stream handshake between the input conditioner and its consumer.
// The conditioner is the master: it drives valid/chan/level, the consumer drives ready.
interface sync_filter_event_if #(
  parameter int CHAN_W = 3
);
  logic              evt_valid;
  logic [CHAN_W-1:0] evt_chan;
  logic              evt_level;
  logic              evt_ready;

  modport master (
    output evt_valid,
    output evt_chan,
    output evt_level,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_chan,
    input  evt_level,
    output evt_ready
  );
endinterface

// File: rtl/sync_filter_event.sv
// Multi-channel async input conditioner: synchronizer chain, stability filter, edge pulses
// and a lowest-index-first event queue with sticky per-channel overrun flags.
module sync_filter_event #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 3,
  parameter int FILTER_LEN = 4,
  parameter int CHAN_W     = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           async_in,
  input  logic [WIDTH-1:0]           rise_en,
  input  logic [WIDTH-1:0]           fall_en,
  output logic [WIDTH-1:0]           data_out,
  output logic [WIDTH-1:0]           rise_pulse,
  output logic [WIDTH-1:0]           fall_pulse,
  output logic [WIDTH-1:0]           overrun,
  input  logic                       ovr_clr,
  sync_filter_event_if.master        evt
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] sq;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] data_q,    data_d;
  logic [WIDTH-1:0] rise_q,    rise_d;
  logic [WIDTH-1:0] fall_q,    fall_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overrun_q, overrun_d;
  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] pop_mask;

  logic              evt_valid_s;
  logic [CHAN_W-1:0] evt_chan_s;
  logic              evt_level_s;
  logic              pop;

  assign sq = sync_q[DEPTH-1];

  // Synchronizer chain: plain flops only, nothing between stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < DEPTH; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Stability filter: a new synced value must persist FILTER_LEN cycles to be accepted.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sq[i] == data_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
        data_d[i] = sq[i];
        cnt_d[i]  = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge detection and event qualification use the level about to be registered,
  // so pulses and pending bits appear in the same cycle as the new data_out.
  always_comb begin
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
    qual   = (rise_d & rise_en) | (fall_d & fall_en);
  end

  // Lowest-index pending channel is presented first.
  always_comb begin
    evt_chan_s  = {CHAN_W{1'b0}};
    evt_level_s = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        evt_chan_s  = CHAN_W'(i);
        evt_level_s = data_q[i];
      end else begin
        evt_chan_s  = evt_chan_s;
        evt_level_s = evt_level_s;
      end
    end
  end

  assign evt_valid_s = |pending_q;
  assign pop         = evt_valid_s & evt.evt_ready;

  // Pending/overrun update; a pop and a fresh qual on the same channel simply re-arm it.
  always_comb begin
    if (pop) begin
      pop_mask = WIDTH'(1) << evt_chan_s;
    end else begin
      pop_mask = {WIDTH{1'b0}};
    end
    pending_d = (pending_q & ~pop_mask) | qual;
    if (ovr_clr) begin
      overrun_d = {WIDTH{1'b0}};
    end else begin
      overrun_d = overrun_q;
    end
    overrun_d = overrun_d | (qual & pending_q & ~pop_mask);
  end

  // Conditioned-state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      data_q    <= {WIDTH{1'b0}};
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      pending_q <= {WIDTH{1'b0}};
      overrun_q <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out      = data_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign overrun       = overrun_q;
  assign evt.evt_valid = evt_valid_s;
  assign evt.evt_chan  = evt_chan_s;
  assign evt.evt_level = evt_level_s;

endmodule
